// File: rtl/order_pkg.sv
// Definitions shared by the order-tagged link: transmitter and receiver use the
// same widths, key table and receiver state encoding.
package order_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  localparam logic [31:0] KEY_A    = 32'h0000_FFFF;
  localparam logic [31:0] KEY_NONE = 32'h0000_0000;

  typedef enum logic {RUN, WAIT} rx_state_t;

  // Indices 0..2 select the scramble key; everything else passes data through.
  function automatic logic [31:0] key_lookup(input logic [2:0] idx);
    return (idx <= 3'd2) ? KEY_A : KEY_NONE;
  endfunction
endpackage

// File: rtl/order_rx_if.sv
// Beat bus between the transmitter (master) and order_rx (slave), including
// the resend-request and status signals that flow back.
interface order_rx_if #(
  parameter int DATA_W = order_pkg::DATA_W,
  parameter int ID_W   = order_pkg::ID_W
);
  logic              vld_i;
  logic [DATA_W-1:0] data_i;
  logic [2:0]        key_index;
  logic [ID_W-1:0]   order_id_i;
  logic              vld_o;
  logic [DATA_W-1:0] data_o;
  logic [ID_W-1:0]   id_o;
  logic              tail_o;
  logic [ID_W-1:0]   exp_id_o;
  logic [7:0]        drop_cnt_o;

  modport master (
    output vld_i, data_i, key_index, order_id_i,
    input  vld_o, data_o, id_o, tail_o, exp_id_o, drop_cnt_o
  );
  modport slave (
    input  vld_i, data_i, key_index, order_id_i,
    output vld_o, data_o, id_o, tail_o, exp_id_o, drop_cnt_o
  );
endinterface

// File: rtl/order_rx_timer.sv
// Resend timeout: counts down from TIMEOUT-1 while enabled and pulses expire
// on the cycle it would pass zero, then reloads itself.
module order_rx_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  assign expire = enable && !clear && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) cnt <= LOAD;
    else if (enable)            cnt <= cnt - 8'd1;
  end
endmodule

// File: rtl/order_rx.sv
// Receive side of the dispatch link: descrambles in-sequence beats, drops
// out-of-order ones and requests a resend, re-requesting on timeout.
module order_rx #(
  parameter int DATA_W  = order_pkg::DATA_W,
  parameter int ID_W    = order_pkg::ID_W,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  order_rx_if.slave  bus
);
  import order_pkg::*;

  rx_state_t         state, state_nx;
  logic              match, expire, deliver, drop, tail_set;
  logic              vld_q, tail_q;
  logic [DATA_W-1:0] data_q;
  logic [ID_W-1:0]   id_q, exp_id;
  logic [7:0]        drop_cnt;

  assign match = bus.vld_i && (bus.order_id_i == exp_id);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (bus.vld_i && !match) state_nx = WAIT;
      WAIT:    if (match)               state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // In WAIT a mismatch alone never re-requests; only the timer does, and a
  // match on the expiry cycle suppresses the expire pulse via enable.
  always_comb begin
    deliver  = match;
    drop     = bus.vld_i && !match;
    tail_set = (state == RUN) ? drop : expire;
  end

  order_rx_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == RUN) || match),
    .enable ((state == WAIT) && !match),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      tail_q   <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      exp_id   <= '0;
      drop_cnt <= '0;
    end else begin
      vld_q  <= deliver;
      tail_q <= tail_set;
      if (deliver) begin
        data_q <= bus.data_i ^ DATA_W'(key_lookup(bus.key_index));
        id_q   <= bus.order_id_i;
        exp_id <= exp_id + ID_W'(1);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.vld_o      = vld_q;
  assign bus.data_o     = data_q;
  assign bus.id_o       = id_q;
  assign bus.tail_o     = tail_q;
  assign bus.exp_id_o   = exp_id;
  assign bus.drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_order_rx.sv
// Randomized and directed bench for order_rx against a behavioural model.
module tb_order_rx;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  order_rx_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus();

  order_rx #(.DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] key_of(input logic [2:0] k);
    return (k < 3'd3) ? 32'h0000_FFFF : 32'h0;
  endfunction

  // Behavioural model: expected id, waiting flag, cycles since last request.
  bit          m_ok = 0, m_vld, m_tail, m_wait;
  logic [31:0] m_data;
  logic [3:0]  m_id, m_exp;
  logic [7:0]  m_drop;
  int          m_since;

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1; m_vld <= 0; m_tail <= 0; m_wait <= 0; m_since <= 0;
      m_data <= '0; m_id <= '0; m_exp <= '0; m_drop <= '0;
    end else begin
      m_vld  <= 0;
      m_tail <= 0;
      if (bus.vld_i && bus.order_id_i == m_exp) begin
        m_vld <= 1; m_data <= bus.data_i ^ key_of(bus.key_index);
        m_id <= bus.order_id_i; m_exp <= m_exp + 4'd1;
        m_wait <= 0; m_since <= 0;
      end else begin
        if (bus.vld_i && m_drop != 8'd255) m_drop <= m_drop + 8'd1;
        if (!m_wait) begin
          if (bus.vld_i) begin m_tail <= 1; m_wait <= 1; m_since <= 0; end
        end else if (m_since + 1 == TIMEOUT) begin
          m_tail <= 1; m_since <= 0;
        end else begin
          m_since <= m_since + 1;
        end
      end
    end
  end

  time tail_t[$];
  int  vld_cnt = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("vld_o",      bus.vld_o,      m_vld);
      chk("tail_o",     bus.tail_o,     m_tail);
      chk("data_o",     bus.data_o,     m_data);
      chk("id_o",       bus.id_o,       m_id);
      chk("exp_id_o",   bus.exp_id_o,   m_exp);
      chk("drop_cnt_o", bus.drop_cnt_o, m_drop);
    end
    if (bus.tail_o === 1'b1) tail_t.push_back($time);
    if (bus.vld_o === 1'b1)  vld_cnt++;
  end

  time t0, t1;

  task automatic drive(input bit r, input bit v, input logic [3:0] id,
                       input logic [2:0] k, input logic [31:0] d);
    @(negedge clk);
    rst = r; bus.vld_i = v; bus.order_id_i = id; bus.key_index = k; bus.data_i = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 3'd0, 32'h0);
  endtask

  task automatic beat(input logic [3:0] id, input logic [2:0] k, input logic [31:0] d);
    drive(0, 1, id, k, d);
  endtask

  // Call only after an idle drive so no beat is repeated across the gap.
  task automatic clr();
    @(posedge clk); #1;
    tail_t.delete();
    vld_cnt = 0;
  endtask

  task automatic do_reset();
    drive(1, 0, 4'd0, 3'd0, 32'h0);
    idle(1);
  endtask

  initial begin
    bus.vld_i = 0; bus.order_id_i = 0; bus.key_index = 0; bus.data_i = 0;
    drive(1, 0, 4'd0, 3'd0, 32'h0);
    drive(1, 0, 4'd0, 3'd0, 32'h0);
    idle(1);
    chk("rst_vld_o", bus.vld_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_exp_id", bus.exp_id_o, 0);
    chk("rst_drop", bus.drop_cnt_o, 0);

    // In-order stream, wrapping back to id 0
    clr();
    for (int i = 0; i < 17; i++) beat(4'(i), 3'd0, 32'h1234_5678);
    idle(2);
    chk("inorder_data", bus.data_o, 32'h1234_A987);
    chk("inorder_exp", bus.exp_id_o, 1);
    chk("inorder_vld_cnt", vld_cnt, 17);
    chk("inorder_tails", tail_t.size(), 0);

    // Gap: 0, 1, 3 with no key
    do_reset(); clr();
    beat(4'd0, 3'd5, 32'hCAFE_0000);
    beat(4'd1, 3'd5, 32'hCAFE_0001);
    beat(4'd3, 3'd5, 32'hCAFE_0003);
    t0 = $time;
    idle(2);
    chk("gap_data", bus.data_o, 32'hCAFE_0001);
    chk("gap_drop", bus.drop_cnt_o, 1);
    chk("gap_exp", bus.exp_id_o, 2);
    chk("gap_tails", tail_t.size(), 1);
    if (tail_t.size() > 0) chk("gap_tail_ofs", (tail_t[0] - t0) / 10, 1);

    // Recovery: 4 dropped, 2 delivered
    clr();
    beat(4'd4, 3'd5, 32'h4);
    beat(4'd2, 3'd5, 32'h2);
    idle(2);
    chk("rec_drop", bus.drop_cnt_o, 2);
    chk("rec_exp", bus.exp_id_o, 3);
    chk("rec_tails", tail_t.size(), 0);
    chk("rec_vld_cnt", vld_cnt, 1);

    // Timeout re-requests at +1, +17, +33
    clr();
    beat(4'd9, 3'd0, 32'h9);
    t0 = $time;
    idle(40);
    chk("to_tails", tail_t.size(), 3);
    if (tail_t.size() == 3) begin
      chk("to_ofs0", (tail_t[0] - t0) / 10, 1);
      chk("to_ofs1", (tail_t[1] - t0) / 10, 17);
      chk("to_ofs2", (tail_t[2] - t0) / 10, 33);
    end
    beat(4'd3, 3'd0, 32'h3);
    idle(1);

    // Expected id lands exactly on the expiry cycle
    clr();
    beat(4'd0, 3'd0, 32'h0);
    idle(15);
    beat(4'd4, 3'd1, 32'h0000_1111);
    t1 = $time;
    idle(20);
    chk("moe_tails", tail_t.size(), 1);
    chk("moe_vld_cnt", vld_cnt, 1);
    chk("moe_data", bus.data_o, 32'h0000_EEEE);
    chk("moe_exp", bus.exp_id_o, 5);
    clr();
    beat(4'd0, 3'd0, 32'h0);
    t0 = $time;
    idle(2);
    chk("moe_run_tails", tail_t.size(), 1);
    if (tail_t.size() > 0) chk("moe_run_ofs", (tail_t[0] - t0) / 10, 1);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0)
        drive(1, 0, 4'd0, 3'd0, 32'h0);
      else
        drive(0, $urandom_range(0, 2) != 0,
              ($urandom_range(0, 3) != 0) ? m_exp : 4'($urandom),
              3'($urandom), $urandom);
    end
    idle(1);

    // Saturation, reset mid-WAIT, first beat after reset
    do_reset();
    for (int i = 0; i < 300; i++) beat(4'd1, 3'd0, $urandom);
    idle(1);
    chk("sat_drop", bus.drop_cnt_o, 255);
    drive(1, 0, 4'd0, 3'd0, 32'h0);
    idle(1);
    chk("mrst_vld", bus.vld_o, 0);
    chk("mrst_tail", bus.tail_o, 0);
    chk("mrst_data", bus.data_o, 0);
    chk("mrst_id", bus.id_o, 0);
    chk("mrst_exp", bus.exp_id_o, 0);
    chk("mrst_drop", bus.drop_cnt_o, 0);
    beat(4'd0, 3'd7, 32'hA5A5_0F0F);
    chk("mrst_tail_next", bus.tail_o, 0);
    idle(1);
    chk("post_vld", bus.vld_o, 1);
    chk("post_data", bus.data_o, 32'hA5A5_0F0F);
    chk("post_exp", bus.exp_id_o, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
